// File: rtl/dsp_t1_mac_sequencer.sv
// Operand-stream sequencer for a dsp_t1 multiply-accumulate block: feeds (a, b) beats
// into the DSP, waits out its pipeline, and returns the dot product with a beat count.
module dsp_t1_mac_sequencer #(
  parameter int unsigned DSP_LATENCY  = 1,
  parameter logic [2:0]  FEEDBACK_SEL = 3'd0
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [19:0] s_a_i,
  input  logic [17:0] s_b_i,
  input  logic        s_valid_i,
  input  logic        s_last_i,
  output logic        s_ready_o,
  input  logic        cfg_unsigned_a_i,
  input  logic        cfg_unsigned_b_i,
  input  logic        cfg_subtract_i,
  output logic [37:0] m_z_o,
  output logic [15:0] m_beats_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [19:0] dsp_a_o,
  output logic [17:0] dsp_b_o,
  output logic        dsp_load_acc_o,
  output logic [2:0]  dsp_feedback_o,
  output logic        dsp_unsigned_a_o,
  output logic        dsp_unsigned_b_o,
  output logic        dsp_subtract_o,
  input  logic [37:0] dsp_z_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] OUTPUT = 2'd3;

  localparam logic [2:0] LAT_LOAD = 3'(DSP_LATENCY);

  logic [1:0]  state_r;
  logic [2:0]  drain_cnt_r;
  logic [15:0] beats_r;
  logic        accept_s;

  assign s_ready_o      = ~reset_i & ((state_r == IDLE) | (state_r == ACCUM));
  assign accept_s       = s_valid_i & s_ready_o;
  assign dsp_feedback_o = FEEDBACK_SEL;

  // Vector sequencing FSM with registered DSP drive and result capture
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r          <= IDLE;
      drain_cnt_r      <= 3'd0;
      beats_r          <= 16'd0;
      m_z_o            <= 38'd0;
      m_beats_o        <= 16'd0;
      m_valid_o        <= 1'b0;
      dsp_a_o          <= 20'd0;
      dsp_b_o          <= 18'd0;
      dsp_load_acc_o   <= 1'b0;
      dsp_unsigned_a_o <= 1'b0;
      dsp_unsigned_b_o <= 1'b0;
      dsp_subtract_o   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          dsp_load_acc_o <= 1'b0;
          if (accept_s) begin
            dsp_a_o          <= s_a_i;
            dsp_b_o          <= s_b_i;
            dsp_unsigned_a_o <= cfg_unsigned_a_i;
            dsp_unsigned_b_o <= cfg_unsigned_b_i;
            dsp_subtract_o   <= cfg_subtract_i;
            beats_r          <= 16'd1;
            drain_cnt_r      <= LAT_LOAD;
            state_r          <= s_last_i ? DRAIN : ACCUM;
          end else begin
            dsp_a_o <= 20'd0;
            dsp_b_o <= 18'd0;
          end
        end
        ACCUM: begin
          // Bubbles feed a zero product so the accumulator holds its value
          dsp_load_acc_o <= 1'b1;
          if (accept_s) begin
            dsp_a_o     <= s_a_i;
            dsp_b_o     <= s_b_i;
            beats_r     <= (beats_r == 16'hFFFF) ? beats_r : beats_r + 16'd1;
            drain_cnt_r <= LAT_LOAD;
            state_r     <= s_last_i ? DRAIN : ACCUM;
          end else begin
            dsp_a_o <= 20'd0;
            dsp_b_o <= 18'd0;
          end
        end
        DRAIN: begin
          dsp_a_o        <= 20'd0;
          dsp_b_o        <= 18'd0;
          dsp_load_acc_o <= 1'b1;
          if (drain_cnt_r == 3'd0) begin
            m_z_o     <= dsp_z_i;
            m_beats_o <= beats_r;
            m_valid_o <= 1'b1;
            state_r   <= OUTPUT;
          end else begin
            drain_cnt_r <= drain_cnt_r - 3'd1;
          end
        end
        OUTPUT: begin
          dsp_a_o        <= 20'd0;
          dsp_b_o        <= 18'd0;
          dsp_load_acc_o <= 1'b1;
          if (m_ready_i) begin
            m_valid_o <= 1'b0;
            state_r   <= IDLE;
          end else begin
            m_valid_o <= 1'b1;
          end
        end
        default: begin
          state_r        <= IDLE;
          m_valid_o      <= 1'b0;
          dsp_a_o        <= 20'd0;
          dsp_b_o        <= 18'd0;
          dsp_load_acc_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
